// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and the memory's write port.
`timescale 1ns/1ps
package imem_loader_pkg;

  localparam int IMEM_DEPTH  = 64;
  localparam int IMEM_ADDR_W = 6;
  localparam int WORD_W      = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_CSUM  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    HDR   = ST_HDR,
    DATA  = ST_DATA,
    WRITE = ST_WRITE,
    CSUM  = ST_CSUM,
    DONE  = ST_DONE,
    ERR   = ST_ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream and keeps the running XOR checksum.
`timescale 1ns/1ps
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word_nxt,
  output logic [7:0]        csum,
  output logic              word_full
);

  logic [1:0]        lane;
  logic [WORD_W-1:0] word_q;

  // word_nxt already contains the byte being loaded, so the caller can capture a complete word
  // on the same edge as the fourth byte.
  always_comb begin
    word_nxt = word_q;
    word_nxt[{lane, 3'b000} +: 8] = byte_data;
  end

  assign word_full = load && (lane == 2'd3);

  // The lane counter wraps 3 -> 0 by itself, so no separate restart is needed between words.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane   <= 2'd0;
      word_q <= '0;
      csum   <= 8'd0;
    end else if (clear) begin
      lane   <= 2'd0;
      word_q <= '0;
      csum   <= 8'd0;
    end else if (load) begin
      lane   <= lane + 2'd1;
      word_q <= word_nxt;
      csum   <= csum ^ byte_data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a framed byte stream, writes the instruction memory and releases
// the core from hold once the image checksum matches.
`timescale 1ns/1ps
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH         = IMEM_DEPTH,
  parameter int ADDR_W        = IMEM_ADDR_W,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  loader_state_t     state, next_state;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W-1:0] word_idx;
  logic              xfer, hdr_bad, last_word;
  logic              pk_clear, pk_load, pk_full;
  logic [WORD_W-1:0] pk_word_nxt;
  logic [7:0]        pk_csum;

  assign xfer      = byte_valid && byte_ready;
  assign hdr_bad   = (byte_data == 8'd0) || (int'(byte_data) > DEPTH);
  assign last_word = ({1'b0, word_idx} == (n_words - (ADDR_W+1)'(1)));

  imem_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .load      (pk_load),
    .byte_data (byte_data),
    .word_nxt  (pk_word_nxt),
    .csum      (pk_csum),
    .word_full (pk_full)
  );

  always_comb begin
    next_state = state;
    pk_clear   = 1'b0;
    pk_load    = 1'b0;
    case (state)
      IDLE, DONE, ERR: if (start) next_state = HDR;
      HDR: begin
        if (xfer) begin
          if (hdr_bad) begin
            next_state = ERR;
          end else begin
            pk_clear   = 1'b1;
            next_state = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          pk_load = 1'b1;
          if (pk_full) next_state = WRITE;
        end
      end
      WRITE: next_state = last_word ? CSUM : DATA;
      CSUM:  if (xfer) next_state = (byte_data == pk_csum) ? DONE : ERR;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so byte_ready and the status levels never depend
  // combinationally on byte_valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      byte_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= HOLD_AT_RESET;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      n_words      <= '0;
      word_idx     <= '0;
    end else begin
      state      <= next_state;
      byte_ready <= (next_state == HDR) || (next_state == DATA) || (next_state == CSUM);
      mem_we     <= (next_state == WRITE);
      done       <= (next_state == DONE);
      err        <= (next_state == ERR);

      case (next_state)
        HDR, ERR: cpu_hold <= 1'b1;
        DONE:     cpu_hold <= 1'b0;
        default:  cpu_hold <= cpu_hold;
      endcase

      if (pk_clear) begin
        n_words  <= byte_data[ADDR_W:0];
        word_idx <= '0;
      end

      if (pk_full) begin
        mem_addr  <= word_idx;
        mem_wdata <= pk_word_nxt;
      end

      if (state == WRITE) begin
        words_loaded <= {1'b0, word_idx} + (ADDR_W+1)'(1);
        if (!last_word) word_idx <= word_idx + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued as frames are driven
// and popped when the loader strobes mem_we.
`timescale 1ns/1ps
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_we, cpu_hold, done, err;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  words_loaded;

  int          check_count = 0;
  int          pass_count  = 0;
  logic [37:0] sb_q[$];
  logic [7:0]  img[256];
  logic        prev_we = 1'b0;

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Write monitor: every strobe must match the next queued write and last one cycle only.
  always @(negedge clk) begin
    if (mem_we) begin
      check_output("we_single_cycle", 32'(prev_we), 32'd0);
      if (sb_q.size() == 0) begin
        check_output("unexpected_we", 32'd1, 32'd0);
      end else begin
        logic [37:0] e;
        e = sb_q.pop_front();
        check_output("wr_addr", 32'(mem_addr), 32'(e[37:32]));
        check_output("wr_data", mem_wdata, e[31:0]);
      end
    end
    prev_we = mem_we;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] calc_csum(input int nw);
    logic [7:0] c = 8'd0;
    for (int i = 0; i < 4*nw; i++) c ^= img[i];
    return c;
  endfunction

  task automatic load_small_image();
    logic [7:0] v[12] = '{8'h83, 8'h00, 8'h00, 8'h00, 8'h03, 8'h01, 8'h40, 8'h00,
                          8'h93, 8'h81, 8'h10, 8'h00};
    for (int i = 0; i < 12; i++) img[i] = v[i];
  endtask

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        byte_valid = 1'b0;
        @(negedge clk);
      end
    end
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) check_output("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [7:0] hdr, input logic [7:0] ck, input bit gaps, input bit glitch);
    int nw;
    nw = (hdr == 8'd0 || hdr > 8'd64) ? 0 : int'(hdr);
    send_byte(hdr, gaps);
    if (nw == 0) return;
    for (int w = 0; w < nw; w++)
      sb_q.push_back({6'(w), img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]});
    for (int i = 0; i < 4*nw; i++) begin
      if (glitch && i == 5) start = 1'b1;
      send_byte(img[i], gaps);
      start = 1'b0;
    end
    send_byte(ck, gaps);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
    repeat (3) @(negedge clk);
    check_output("rst_byte_ready", 32'(byte_ready), 32'd0);
    check_output("rst_mem_we", 32'(mem_we), 32'd0);
    check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_output("rst_mem_wdata", mem_wdata, 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_words_loaded", 32'(words_loaded), 32'd0);
    check_output("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_output("idle_byte_ready", 32'(byte_ready), 32'd0);

    $display("[TB] 3-word load with gaps and a start pulse while busy");
    load_small_image();
    check_output("model_csum", 32'(calc_csum(3)), 32'h0000_00C3);
    do_start();
    check_output("hdr_byte_ready", 32'(byte_ready), 32'd1);
    check_output("hdr_cpu_hold", 32'(cpu_hold), 32'd1);
    apply_stimulus(8'h03, 8'hC3, 1'b1, 1'b1);
    check_output("ok3_done", 32'(done), 32'd1);
    check_output("ok3_cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("ok3_words_loaded", 32'(words_loaded), 32'd3);
    check_output("ok3_err", 32'(err), 32'd0);
    check_output("ok3_byte_ready", 32'(byte_ready), 32'd0);
    check_output("ok3_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] bad checksum then a good reload");
    do_start();
    check_output("reload_done_clr", 32'(done), 32'd0);
    check_output("reload_cpu_hold", 32'(cpu_hold), 32'd1);
    apply_stimulus(8'h03, 8'hC2, 1'b1, 1'b0);
    check_output("badck_err", 32'(err), 32'd1);
    check_output("badck_done", 32'(done), 32'd0);
    check_output("badck_cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("badck_sb_empty", 32'(sb_q.size()), 32'd0);
    do_start();
    check_output("retry_err_clr", 32'(err), 32'd0);
    apply_stimulus(8'h03, 8'hC3, 1'b0, 1'b0);
    check_output("retry_done", 32'(done), 32'd1);

    $display("[TB] illegal headers");
    for (int k = 0; k < 2; k++) begin
      logic [7:0] hb;
      hb = (k == 0) ? 8'h00 : 8'h41;
      do_start();
      apply_stimulus(hb, 8'h00, 1'b0, 1'b0);
      check_output("badhdr_err", 32'(err), 32'd1);
      check_output("badhdr_done", 32'(done), 32'd0);
      check_output("badhdr_byte_ready", 32'(byte_ready), 32'd0);
      check_output("badhdr_cpu_hold", 32'(cpu_hold), 32'd1);
      repeat (3) @(negedge clk);
      check_output("badhdr_err_held", 32'(err), 32'd1);
    end

    $display("[TB] full 64-word image");
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    do_start();
    apply_stimulus(8'h40, calc_csum(64), 1'b1, 1'b0);
    check_output("full_done", 32'(done), 32'd1);
    check_output("full_words_loaded", 32'(words_loaded), 32'd64);
    check_output("full_last_addr", 32'(mem_addr), 32'd63);
    check_output("full_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] reset during word 1");
    load_small_image();
    do_start();
    send_byte(8'h03, 1'b0);
    sb_q.push_back({6'd0, img[3], img[2], img[1], img[0]});
    for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0);
    check_output("midload_state", 32'(dut.state), 32'(DATA));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_output("midrst_state", 32'(dut.state), 32'(IDLE));
    check_output("midrst_byte_ready", 32'(byte_ready), 32'd0);
    check_output("midrst_mem_we", 32'(mem_we), 32'd0);
    check_output("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("midrst_done", 32'(done), 32'd0);
    check_output("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
    do_start();
    apply_stimulus(8'h03, 8'hC3, 1'b0, 1'b0);
    check_output("recover_done", 32'(done), 32'd1);
    check_output("recover_words_loaded", 32'(words_loaded), 32'd3);

    repeat (3) @(negedge clk);
    check_output("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the 64-word instruction memory. Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues one-cycle write strobes to the memory's write port.
- Holds the pipelined core in reset-hold until a complete, checksum-verified image is loaded.
- Sits between the host/UART byte source and the instruction memory. The core's fetch path stays read-only.

Parameters:
- DEPTH, 64, number of 32-bit instruction words; also the largest legal word count.
- ADDR_W, 6, word-address width; must equal clog2(DEPTH).
- HOLD_AT_RESET, 1, value of cpu_hold after reset. Set to 0 for simulations that use a preloaded memory.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low. Sampled on the clk rising edge; 0 resets the block.
- start  in  1  begin a load. Sampled only in IDLE, DONE and ERR.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word offset of the write.
- mem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  keeps the core's PC/pipeline frozen.
- done  out  1  level; image loaded and checksum matched.
- err  out  1  level; bad header or checksum mismatch.
- words_loaded  out  ADDR_W+1  count of words written in the current or last load.

Behaviour:
- Transfer rule: a byte transfers on a rising edge where byte_valid && byte_ready. byte_ready is a registered function of state only and never depends on byte_valid.
- Reset values: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, words_loaded=0, cpu_hold=HOLD_AT_RESET.
- Reset mid-load: returns to IDLE immediately. Partially written memory contents are left as-is.
- Frame format: header byte N (word count), then 4*N data bytes (LSB first per word), then one checksum byte. The checksum is the XOR of all 4*N data bytes.
- IDLE: byte_ready=0. start=1 -> HDR; cpu_hold<=1, done<=0, err<=0.
- HDR: byte_ready=1. On transfer:
  - N==0 or N>DEPTH -> ERR.
  - Otherwise latch N; word_idx<=0, lane<=0, csum<=0; -> DATA.
- DATA: byte_ready=1. On transfer:
  - byte goes into bits [8*lane+7:8*lane] of the word register; csum^=byte; lane++.
  - Transfer with lane==3 -> WRITE.
- WRITE (exactly one cycle): byte_ready=0, mem_we=1, mem_addr=word_idx, mem_wdata=assembled word.
  - words_loaded<=word_idx+1.
  - word_idx==N-1 -> CSUM; else word_idx++, lane<=0 -> DATA.
- Latency: a 4th-byte transfer at edge t gives mem_we high in cycle t+1, and next byte acceptance no earlier than cycle t+2.
- Signals outside WRITE: mem_we=0. mem_addr/mem_wdata hold their last values.
- CSUM: byte_ready=1. On transfer: byte==csum -> DONE, else -> ERR.
- DONE: done=1, cpu_hold=0, byte_ready=0. start=1 -> HDR (reload; done and err clear, cpu_hold=1).
- ERR: err=1, cpu_hold=1, byte_ready=0. start=1 -> HDR (err clears).
- start in HDR/DATA/WRITE/CSUM is ignored.
- byte_valid while byte_ready=0 is ignored; the source must hold the byte.
- Address wrap: impossible, since N is bounded by DEPTH and word_idx never exceeds DEPTH-1.
- words_loaded: saturates at DEPTH (7 bits for DEPTH=64).

Decomposition:
- Shared package: state encoding (IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR as 3-bit localparams), DEPTH/ADDR_W defaults, and the instruction-word width constant 32. All are reused by the instruction memory's new write port.
- One natural sub-module: imem_word_packer. It holds the lane counter, shifts bytes into a 32-bit register, keeps the running XOR, and flags word_full. The FSM stays in imem_loader.

Test Plan:
- 3-word load: start, bytes 03, then 83 00 00 00, 03 01 40 00, 93 81 10 00, checksum C3.
  - Writes are 0x00000083@0, 0x00400103@1, 0x00108193@2.
  - Result: done=1, cpu_hold=0, words_loaded=3, err=0.
- Bad checksum: same frame with checksum C2 -> all three writes occur, then err=1, done=0, cpu_hold=1. A later start plus a good frame -> done=1.
- Illegal header: N=00, and separately N=41 (65) -> ERR on the header transfer, no mem_we pulse, byte_ready=0.
- Backpressure/gaps: byte_valid toggled randomly, with byte_valid held during the WRITE cycle.
  - The held byte is not consumed during WRITE.
  - Each byte is consumed exactly once; mem_we is a single-cycle pulse per word.
- Full image: N=40 (64) with 256 data bytes -> 64 writes at addresses 0..63 in order, words_loaded=64, done=1.
- Reset mid-load: rst=0 for one edge during DATA of word 1 -> next cycle state IDLE, byte_ready=0, mem_we=0, cpu_hold=HOLD_AT_RESET. Ignoring start pulses while busy is also checked.
